lsu_load_unit: RTL
==================

# lsu_load_unit

Read-side controller of the LSU in the MA stage: accepts one load request at a time, issues a single word read to data memory or the peripheral register space, and waits for the read data. It then aligns and sign/zero-extends the addressed byte, half or word, and returns the result with its destination-register tag over a valid/ready handshake. It is the reader counterpart of the enabled storage registers that the store path writes. Erroneous loads return an error flag instead of data; the scoreboard/writeback logic consumes the response.

## Interface
- AW, 32, address width
- TIMEOUT, 16, maximum WAIT cycles before an error response; must be ≥2
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  unit can accept a request
- req_addr  in  AW  byte address
- req_funct3  in  3  RV32I load funct3
- req_rd  in  5  destination register tag
- mem_req  out  1  one-cycle read strobe
- mem_addr  out  AW  word address: {addr[AW-1:2], 2'b00}
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  formatted load data
- rsp_rd  out  5  tag of the request
- rsp_err  out  1  illegal funct3, misaligned access (macro), or timeout

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, funct3 and rd.
  - Legal, aligned request → ISSUE.
  - Illegal funct3 (011, 110, 111) → RESP with rsp_err=1, rsp_data=0, no mem_req.
- ISSUE: mem_req=1 for exactly one cycle, then WAIT. Clear the timeout counter.
- WAIT: on mem_rvalid, register the formatted data and enter RESP with rsp_err=0. Otherwise increment the counter; when it reaches TIMEOUT-1 without rvalid, enter RESP with rsp_err=1 and rsp_data=0.
- RESP: rsp_valid=1, with data, tag and err held stable. On rsp_ready, go to IDLE.
- Formatting (lane = addr[1:0]):
  - LB / LBU: byte at lane, sign- or zero-extended.
  - LH / LHU: half at addr[1], sign- or zero-extended.
  - LW: full word.
- mem_rvalid is ignored in IDLE, ISSUE and RESP.
- If mem_rvalid arrives in the same cycle the timeout expires, the data wins (rsp_err=0).
- Reset values: state=IDLE, req_ready=1 after reset, mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0, counter=0.
- Reset mid-operation aborts the load silently. A late mem_rvalid after reset is ignored.

## Timing
- Accept at edge E0 (req_valid & req_ready).
- mem_req is high during the cycle after E0.
- For a memory returning rvalid L cycles after mem_req (L≥1), rsp_valid rises 2+L cycles after E0.
- Error paths that skip the memory access (illegal funct3, misaligned under macro) raise rsp_valid 1 cycle after E0.
- req_ready=0 from E0 until the edge at which the response handshake completes. The next request is accepted at the earliest one cycle later (no overlap).
- rsp_* must not change while rsp_valid=1 and rsp_ready=0.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - LH/LHU with addr[0]=1, or LW with addr[1:0]≠0, produce an error response with no mem_req.
  - Response arrives 1 cycle after accept, with rsp_err=1 and rsp_data=0.
- LSU_MISALIGN_TRAP_EN undefined:
  - Such requests are issued normally, using the truncated lane (half uses addr[1], word ignores addr[1:0]).
  - rsp_err=0 unless a timeout occurs.

## Structure
- lsu_pkg contains:
  - load_op_e (funct3 encodings LB=000, LH=001, LW=010, LBU=100, LHU=101)
  - state enum
  - default TIMEOUT constant
- One combinational sub-module, lsu_load_fmt (inputs: rdata, funct3, addr[1:0]; output: 32-bit formatted data), which is reusable and tested standalone.
- The timeout counter is $clog2(TIMEOUT+1) bits wide, saturating, and lives in the top.

## Test plan
- LB at addr 0x103, mem_rdata 0x80FF_1234, L=1 → mem_addr 0x100, rsp_data 0xFFFF_FF80, rsp_err=0; rsp_valid 3 cycles after accept.
- LHU at 0x202, rdata 0xBEEF_0001 → 0x0000_BEEF. LH with the same data → 0xFFFF_BEEF. rsp_rd echoes the request tag.
- funct3=011 → no mem_req; rsp_err=1, rsp_data=0 one cycle after accept.
- No rvalid with TIMEOUT=16 → rsp_err=1 after 16 WAIT cycles. rvalid in the 16th WAIT cycle → data returned, rsp_err=0.
- rsp_ready held low 5 cycles → rsp outputs stable, req_ready=0, a new req_valid is not accepted. rst_n pulsed low in WAIT → all outputs 0, state IDLE, and a subsequent stray rvalid is ignored.
- LW at 0x006: with LSU_MISALIGN_TRAP_EN → immediate rsp_err=1, no mem_req. Without it → mem_addr 0x004, full word returned.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared types and constants for the LSU load path.
//   - load_op_e   : RV32I load funct3 encodings
//   - lsu_state_e : load controller FSM states
//   - LSU_TIMEOUT_DEF / LSU_AW_DEF : default parameter values
//   - is_legal_load / is_misaligned : request classification helpers
//   Optional feature macro used by the top: LSU_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LH  = 3'b001,
      OP_LW  = 3'b010,
      OP_LBU = 3'b100,
      OP_LHU = 3'b101
   } load_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

   localparam int LSU_TIMEOUT_DEF = 16;
   localparam int LSU_AW_DEF      = 32;

   // funct3 values 011, 110 and 111 have no load meaning in RV32I.
   function automatic logic is_legal_load(input logic [2:0] funct3);
      logic legal;
      case (funct3)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: legal = 1'b1;
         default:                             legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Byte loads can never be misaligned; halves need addr[0]=0, words addr[1:0]=0.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
      logic mis;
      case (funct3)
         OP_LH, OP_LHU: mis = lane[0];
         OP_LW:         mis = (lane != 2'b00);
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_load_unit_if.sv
// -----------------------------------------------------------------------------
// lsu_load_unit_if
//   Bundles the three handshakes of the load unit:
//   - request  : req_valid/req_ready, req_addr, req_funct3, req_rd
//   - memory   : mem_req strobe + mem_addr, mem_rvalid + mem_rdata
//   - response : rsp_valid/rsp_ready, rsp_data, rsp_rd, rsp_err
//   Handshake rule: a transfer happens on a rising edge where valid and ready
//   are both high; once valid is raised the payload is held until that edge.
//   modport slave  : the load unit
//   modport master : the requester / memory / consumer environment
// -----------------------------------------------------------------------------
interface lsu_load_unit_if #(
   parameter int AW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [2:0]    req_funct3;
   logic [4:0]    req_rd;

   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_data;
   logic [4:0]    rsp_rd;
   logic          rsp_err;

   modport slave (
      input  req_valid, req_addr, req_funct3, req_rd,
      output req_ready,
      output mem_req, mem_addr,
      input  mem_rvalid, mem_rdata,
      output rsp_valid, rsp_data, rsp_rd, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_addr, req_funct3, req_rd,
      input  req_ready,
      input  mem_req, mem_addr,
      output mem_rvalid, mem_rdata,
      input  rsp_valid, rsp_data, rsp_rd, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/lsu_load_fmt.sv
// -----------------------------------------------------------------------------
// lsu_load_fmt
//   Combinational load data formatter: picks the addressed byte/half/word out
//   of a 32-bit read word and sign- or zero-extends it.
//   Ports:
//     rdata   in  32  raw read word
//     funct3  in  3   RV32I load funct3
//     addr_lo in  2   byte lane (addr[1:0]); halves use addr_lo[1] only
//     data    out 32  formatted result (0 for illegal funct3)
// -----------------------------------------------------------------------------
module lsu_load_fmt
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  data = {24'h0, byte_sel};
         OP_LH:   data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  data = {16'h0, half_sel};
         OP_LW:   data = rdata;
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_load_unit.sv
// -----------------------------------------------------------------------------
// lsu_load_unit
//   MA-stage load controller: accepts one load at a time, issues a single
//   word read, waits (bounded by TIMEOUT) for read data, formats it and
//   returns it with the destination tag, or returns an error response.
//   Ports:
//     clk       in   clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     bus       slave modport of lsu_load_unit_if (request/memory/response)
//     dbg_state out  current FSM state
//   Parameters: AW (address width), TIMEOUT (max WAIT cycles, >= 2).
//   Optional feature: define LSU_MISALIGN_TRAP_EN to turn misaligned LH/LHU/LW
//   into immediate error responses; otherwise they are issued with the
//   address truncated to the access size.
// -----------------------------------------------------------------------------
module lsu_load_unit
   import lsu_pkg::*;
#(
   parameter int AW      = LSU_AW_DEF,
   parameter int TIMEOUT = LSU_TIMEOUT_DEF
)(
   input  logic                clk,
   input  logic                rst_n,
   lsu_load_unit_if.slave      bus,
   output lsu_state_e          dbg_state
);

   localparam int               CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]    CNT_MAX  = {CW{1'b1}};

   lsu_state_e     state_q, state_d;
   logic [AW-1:0]  addr_q,  addr_d;
   logic [2:0]     f3_q,    f3_d;
   logic [4:0]     rd_q,    rd_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic [31:0]    data_q,  data_d;
   logic           err_q,   err_d;

   logic [31:0]    fmt_data;
   logic           req_mis;

   // Formatting uses the latched request, so the result only depends on the
   // read word in the cycle mem_rvalid is seen.
   lsu_load_fmt u_fmt (
      .rdata   (bus.mem_rdata),
      .funct3  (f3_q),
      .addr_lo (addr_q[1:0]),
      .data    (fmt_data)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_mis = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
   assign req_mis = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d = bus.req_addr;
               f3_d   = bus.req_funct3;
               rd_d   = bus.req_rd;
               data_d = 32'h0;
               if (!is_legal_load(bus.req_funct3) || req_mis) begin
                  // Error without touching memory: response next cycle.
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Data beats the timeout when both happen in the same cycle.
            if (bus.mem_rvalid) begin
               data_d  = fmt_data;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               data_d  = 32'h0;
               err_d   = 1'b1;
               state_d = RESP;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         f3_q    <= 3'b000;
         rd_q    <= 5'd0;
         cnt_q   <= '0;
         data_q  <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.mem_req   = (state_q == ISSUE);
   assign bus.mem_addr  = {addr_q[AW-1:2], 2'b00};
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_data  = data_q;
   assign bus.rsp_rd    = rd_q;
   assign bus.rsp_err   = err_q;
   assign dbg_state     = state_q;

endmodule
